instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the combinational instruction memory. It owns the program counter and drives the memory address. It captures the returned 32-bit instruction word with its PC into a 2-entry buffer and presents it to the decode stage over a valid/ready handshake. It handles branch redirects and stops at the end-of-program word.

---
 rtl/instr_fetch_unit_pkg.sv | 35 +++
 rtl/instr_fetch_unit_fetch_buffer.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 80 ++++++++
 tb/tb_instr_fetch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: widths, halt marker,
// instruction field positions and the buffered fetch entry.
package instr_fetch_unit_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC  = '0;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

  // Instruction field layout as seen by decode
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int RD_MSB     = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_MSB     = 21;
  localparam int RS_LSB     = 16;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry in-order buffer between fetch and decode. Slot 0 is always the
// head, so the head is stable whenever nothing is popped.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         pop_eff;
  logic         push_eff;

  assign pop_eff  = pop && (count != 2'd0);
  assign push_eff = push && ((count != 2'd2) || pop_eff);
  assign head     = slot0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// feeds decode through a 2-entry buffer; stops at the halt word.
//
// state    | meaning
// ST_FETCH | PC advances on every accepted fetch
// ST_HALT  | halt word seen; PC parked on it until redirect or reset
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               id_ready,
  output logic               halted
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            pop;
  logic            push_ok;
  logic            push;

  assign pc_addr   = pc;
  assign halted    = (state == ST_HALT);
  assign id_valid  = (count != 2'd0);
  assign id_instr  = head.instr;
  assign id_pc     = head.pc;
  assign pop       = id_valid && id_ready;
  assign push_ok   = !halted && ((count != 2'd2) || pop);
  assign push_data = '{pc: pc, instr: imem_instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Redirect wins over everything; a halt word is never pushed
  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    if (redirect_valid) begin
      state_next = ST_FETCH;
      pc_next    = redirect_pc;
    end else if (push_ok) begin
      if (imem_instr == HALT_WORD) begin
        state_next = ST_HALT;
      end else begin
        push    = 1'b1;
        pc_next = pc + 1'b1;
      end
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a queue-level model of the fetch
// rules predicts delivered words; a posedge monitor checks each handshake.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PC_W-1:0]    pc_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic               id_ready;
  logic               halted;

  typedef struct {
    int          pc;
    logic [31:0] instr;
  } exp_t;

  logic [31:0] mem [64];
  exp_t        mq[$];
  exp_t        exp_q[$];
  int          m_pc;
  bit          m_halt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[pc_addr];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_addr        (pc_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .halted         (halted)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every decode handshake must match the oldest expected entry
  always @(posedge clk) begin : monitor
    exp_t e;
    if (rst_n && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got pc %0d instr %0h, nothing expected", id_pc, id_instr);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", 32'(id_pc), 32'(e.pc));
        chk("id_instr", id_instr, e.instr);
      end
    end
  end

  // Called at a negedge: check visible state, drive inputs, advance model
  task automatic step(input bit rv, input int rpc, input bit rdy);
    exp_t e;
    int   drop;
    chk("pc_addr", 32'(pc_addr), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    redirect_valid = rv;
    redirect_pc    = rpc[5:0];
    id_ready       = rdy;
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (rv) begin
      drop = mq.size();
      mq.delete();
      repeat (drop) void'(exp_q.pop_back());
      m_pc   = rpc;
      m_halt = 1'b0;
    end else if (!m_halt && mq.size() < 2) begin
      if (mem[m_pc] == 32'h0) begin
        m_halt = 1'b1;
      end else begin
        e.pc    = m_pc;
        e.instr = mem[m_pc];
        mq.push_back(e);
        exp_q.push_back(e);
        m_pc = (m_pc + 1) % 64;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_pc_addr", 32'(pc_addr), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    mq.delete();
    exp_q.delete();
    m_pc   = 0;
    m_halt = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0020_0003;
    mem[1] = 32'h0040_0002;
    mem[2] = 32'h1064_0022;
  endtask

  task automatic load_random();
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 99) < 12) ? 32'h0 : $urandom;
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    m_pc           = 0;
    m_halt         = 1'b0;
    load_prog();
    repeat (2) @(negedge clk);
    chk("reset_id_valid", 32'(id_valid), 32'd0);
    chk("reset_id_instr", id_instr, 32'd0);
    chk("reset_id_pc", 32'(id_pc), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_pc_addr", 32'(pc_addr), 32'd0);
    rst_n = 1'b1;

    // Straight-line program to the halt word
    repeat (8) step(0, 0, 1);
    chk("prog_halted", 32'(halted), 32'd1);
    chk("prog_halt_pc", 32'(pc_addr), 32'd3);

    // Backpressure from decode
    do_reset();
    repeat (5) step(0, 0, 0);
    repeat (8) step(0, 0, 1);

    // Redirect with a full buffer
    do_reset();
    repeat (3) step(0, 0, 0);
    step(1, 1, 0);
    repeat (6) step(0, 0, 1);

    // Redirect out of halt replays the program
    step(1, 0, 1);
    repeat (6) step(0, 0, 1);

    // PC wrap at the top of the address space
    for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_0001;
    step(1, 63, 1);
    repeat (5) step(0, 0, 1);

    // Asynchronous reset with a full buffer, then restart
    load_prog();
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    do_reset();
    repeat (6) step(0, 0, 1);

    // Randomized traffic
    load_random();
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 499) load_random();
      if (n % 700 == 699) do_reset();
      step($urandom_range(0, 99) < 5, int'($urandom_range(0, 63)),
           $urandom_range(0, 99) < 70);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
